display_scan_7seg: RTL and testbench

DISPLAY_SCAN_7SEG -- requirements
Module: display_scan_7seg

---
 rtl/display_scan_7seg.sv | 163 ++++++++++++++++
 tb/tb_display_scan_7seg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_7seg.sv
// rtl/display_scan_7seg.sv - multiplexed 4-digit 7-segment clock display scanner
//
// Ports:
//   clk          master clock, all state on the rising edge
//   rst          asynchronous reset, active low
//   M0, M1, H0   minutes units/tens, hours units (BCD, 4'hF = blank)
//   H1           hours tens 0-2 (2'b11 = blank)
//   Dots         colon blink input, asynchronous to the scan
//   seg          registered segments {g,f,e,d,c,b,a}
//   dp           registered colon/decimal-point segment
//   an           registered digit enables, an[0]=M0 .. an[3]=H1
module display_scan_7seg #(
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK_CYC   = 8,
    parameter int LZ_SUPPRESS = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] M0,
    input  logic [3:0] M1,
    input  logic [3:0] H0,
    input  logic [1:0] H1,
    input  logic       Dots,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [3:0] AN_OFF  = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic          slot_end;

    logic [3:0] sh_m0, sh_m1, sh_h0;
    logic [1:0] sh_h1;
    logic       sh_dots;
    logic       dots_s1, dots_s2;

    logic [3:0] digit;
    logic [6:0] seg_act;
    logic       dp_act;
    logic [3:0] an_act;

    assign slot_end = (pcnt == PW'(SCAN_DIV - 1));

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            4'hF:    dec7 = 7'h00;
            default: dec7 = 7'h40;
        endcase
    endfunction

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_BLANK;
        else      state <= state_nxt;
    end

    // state always mirrors pcnt: BLANK while pcnt < BLANK_CYC
    always_comb begin
        state_nxt = state;
        if (slot_end)
            state_nxt = ST_BLANK;
        else if (state == ST_BLANK && pcnt == PW'(BLANK_CYC - 1))
            state_nxt = ST_SHOW;
    end

    // Colon synchronizer and frame shadows; shadows load only when a
    // full frame has been scanned so a frame never mixes old and new time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dots_s1 <= 1'b0;
            dots_s2 <= 1'b0;
            sh_m0   <= 4'hF;
            sh_m1   <= 4'hF;
            sh_h0   <= 4'hF;
            sh_h1   <= 2'b11;
            sh_dots <= 1'b0;
        end else begin
            dots_s1 <= Dots;
            dots_s2 <= dots_s1;
            if (slot_end && idx == 2'd3) begin
                sh_m0   <= M0;
                sh_m1   <= M1;
                sh_h0   <= H0;
                sh_h1   <= H1;
                sh_dots <= dots_s2;
            end
        end
    end

    always_comb begin
        digit   = 4'hF;
        seg_act = 7'h00;
        dp_act  = 1'b0;
        an_act  = 4'h0;
        case (idx)
            2'd0: digit = sh_m0;
            2'd1: digit = sh_m1;
            2'd2: digit = sh_h0;
            default: begin
                if (sh_h1 == 2'b11 || (LZ_SUPPRESS != 0 && sh_h1 == 2'b00))
                    digit = 4'hF;
                else
                    digit = {2'b00, sh_h1};
            end
        endcase
        if (state == ST_SHOW) begin
            an_act  = 4'b0001 << idx;
            seg_act = dec7(digit);
            dp_act  = (idx == 2'd2) && sh_dots;
        end
    end

    // Output registers; async reset forces the inactive levels immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= (SEG_ACT_LOW != 0) ? ~seg_act : seg_act;
            dp  <= (SEG_ACT_LOW != 0) ? ~dp_act  : dp_act;
            an  <= (AN_ACT_LOW  != 0) ? ~an_act  : an_act;
        end
    end

endmodule

// File: tb/tb_display_scan_7seg.sv
// tb/tb_display_scan_7seg.sv - randomized model-checked bench for display_scan_7seg
module tb_display_scan_7seg;

    localparam int D  = 10;
    localparam int BC = 2;
    localparam int FR = 4 * D;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] M0 = 4'd4, M1 = 4'd3, H0 = 4'd2;
    logic [1:0] H1 = 2'd1;
    logic       Dots = 1'b0;

    logic [6:0] seg1, seg0;
    logic       dp1, dp0;
    logic [3:0] an1, an0;

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;

    logic [3:0] m0_h [0:8191];
    logic [3:0] m1_h [0:8191];
    logic [3:0] h0_h [0:8191];
    logic [1:0] h1_h [0:8191];
    logic       dt_h [0:8191];

    display_scan_7seg #(.SCAN_DIV(D), .BLANK_CYC(BC), .LZ_SUPPRESS(1)) u_lz1 (
        .clk(clk), .rst(rst), .M0(M0), .M1(M1), .H0(H0), .H1(H1), .Dots(Dots),
        .seg(seg1), .dp(dp1), .an(an1)
    );

    display_scan_7seg #(.SCAN_DIV(D), .BLANK_CYC(BC), .LZ_SUPPRESS(0)) u_lz0 (
        .clk(clk), .rst(rst), .M0(M0), .M1(M1), .H0(H0), .H1(H1), .Dots(Dots),
        .seg(seg0), .dp(dp0), .an(an0)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release plus per-edge input history
    always @(posedge clk) begin
        if (!rst) begin
            ecnt <= 0;
        end else begin
            ecnt <= ecnt + 1;
            m0_h[ecnt+1] <= M0;
            m1_h[ecnt+1] <= M1;
            h0_h[ecnt+1] <= H0;
            h1_h[ecnt+1] <= H1;
            dt_h[ecnt+1] <= Dots;
        end
    end

    function automatic logic [6:0] dec7(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  15: return 7'h00;
            default: return 7'h40;
        endcase
    endfunction

    // Output expected after rising edge e (e=1 is the first edge after reset)
    function automatic void model(input int e, input bit lz,
                                  output logic [3:0] an_e, output logic [6:0] seg_e,
                                  output logic dp_e);
        int p, slot, f, k, v;
        logic dots;
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
        if (e < 1) return;
        p    = (e - 1) % D;
        slot = ((e - 1) / D) % 4;
        f    = (e - 1) / FR;
        if (p < BC) return;
        an_e = ~(4'b0001 << slot);
        v    = 15;
        dots = 1'b0;
        if (f > 0) begin
            k = FR * f;
            dots = dt_h[k-2];
            case (slot)
                0: v = int'(m0_h[k]);
                1: v = int'(m1_h[k]);
                2: v = int'(h0_h[k]);
                default: begin
                    v = int'(h1_h[k]);
                    if (v == 3 || (lz && v == 0)) v = 15;
                end
            endcase
        end
        seg_e = ~dec7(v);
        dp_e  = !(slot == 2 && dots);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s e=%0d got=%0h expected=%0h", name, ecnt, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        logic [3:0] ae;
        logic [6:0] se;
        logic       de;
        model(rst ? ecnt : 0, 1'b1, ae, se, de);
        chk("lz1_an", int'(an1), int'(ae));
        chk("lz1_seg", int'(seg1), int'(se));
        chk("lz1_dp", int'(dp1), int'(de));
        model(rst ? ecnt : 0, 1'b0, ae, se, de);
        chk("lz0_an", int'(an0), int'(ae));
        chk("lz0_seg", int'(seg0), int'(se));
        chk("lz0_dp", int'(dp0), int'(de));
    end

    task automatic at_edge(input int target);
        int guard = 0;
        while (ecnt < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt < target) begin
            $display("FAIL timeout waiting for edge %0d", target);
            fails++;
        end
    endtask

    task automatic lit(input string name, input int target, input logic [3:0] a,
                       input logic [6:0] s, input logic d);
        at_edge(target);
        chk({name, "_an"}, int'(an1), int'(a));
        chk({name, "_seg"}, int'(seg1), int'(s));
        chk({name, "_dp"}, int'(dp1), int'(d));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", int'(an1), 4'hF);
        chk("rst_seg", int'(seg1), 7'h7F);
        chk("rst_dp", int'(dp1), 1);
        rst = 1'b1;

        // frame 0 shows blanks; frame 2 shows 12:34
        lit("f0_blankoff", 1, 4'hF, 7'h7F, 1'b1);
        lit("f0_blank", 3, 4'b1110, 7'h7F, 1'b1);
        lit("f2_dead", 81, 4'hF, 7'h7F, 1'b1);
        lit("f2_d0", 83, 4'b1110, 7'h19, 1'b1);
        lit("f2_d1", 93, 4'b1101, 7'h30, 1'b1);
        lit("f2_d2", 103, 4'b1011, 7'h24, 1'b1);
        lit("f2_d3", 113, 4'b0111, 7'h79, 1'b1);
        lit("f2_d3end", 120, 4'b0111, 7'h79, 1'b1);

        at_edge(121);
        Dots = 1'b1;
        H1   = 2'd0;
        lit("f4_d1dp", 173, 4'b1101, 7'h30, 1'b1);
        lit("f4_dp", 183, 4'b1011, 7'h24, 1'b0);
        lit("f4_lz", 193, 4'b0111, 7'h7F, 1'b1);
        chk("f4_nolz_seg", int'(seg0), 7'h40);

        at_edge(201);
        M0 = 4'hF;
        M1 = 4'hA;
        lit("f6_blank", 243, 4'b1110, 7'h7F, 1'b1);
        lit("f6_dash", 253, 4'b1101, 7'h3F, 1'b1);
        lit("f6_dp", 263, 4'b1011, 7'h24, 1'b0);
        Dots = 1'b0;
        lit("f6_dp_hold", 268, 4'b1011, 7'h24, 1'b0);
        lit("f7_dp_off", 303, 4'b1011, 7'h24, 1'b1);

        // Random input changes at arbitrary points inside frames
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 11))
                0: M0 = 4'($urandom_range(0, 15));
                1: M1 = 4'($urandom_range(0, 15));
                2: H0 = 4'($urandom_range(0, 15));
                3: H1 = 2'($urandom_range(0, 3));
                4: Dots = ~Dots;
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a SHOW phase
        while (((ecnt - 1) % D) != 5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_an", int'(an1), 4'hF);
        chk("arst_seg", int'(seg1), 7'h7F);
        chk("arst_dp", int'(dp1), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        M0 = 4'd7; M1 = 4'd5; H0 = 4'd9; H1 = 2'd2;
        lit("post_rst_blank", 3, 4'b1110, 7'h7F, 1'b1);
        lit("post_rst_h1", 33, 4'b0111, 7'h7F, 1'b1);
        lit("post_rst_d0", 43, 4'b1110, 7'h78, 1'b1);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                M0   = 4'($urandom_range(0, 15));
                H1   = 2'($urandom_range(0, 3));
                Dots = 1'($urandom_range(0, 1));
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
